pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised elastic register chain: DEPTH stages of WIDTH-bit registers with valid/ready
//   handshake, bubble collapsing and synchronous flush. Generalises the single enable-gated
//   D flip-flop used for timing cuts and latency balancing between LWC datapath units.
// PARAMETERS
//   WIDTH  32  data bits per stage
//   DEPTH  2   number of register stages (>=1); nominal latency in cycles
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset (rst==0 resets)
//   flush      in   1      synchronous clear of all stage valid bits
//   in_data    in   WIDTH  upstream data
//   in_valid   in   1      upstream data valid
//   in_ready   out  1      chain can accept in_data this cycle
//   out_data   out  WIDTH  data of last stage
//   out_valid  out  1      last stage holds valid data
//   out_ready  in   1      downstream accepts out_data this cycle
//   occupancy  out  $clog2(DEPTH+1)  valid-stage count (only with PIPE_REG_CHAIN_OCC_EN)
// BEHAVIOUR
//   - Reset (rst low, async): all valid bits 0, all stage data 0, occupancy 0;
//     hence out_valid=0, out_data=0. Reset mid-transfer discards all content; no partial state.
//   - Stage i holds data[i], v[i]; stage 0 at input, stage DEPTH-1 drives out_data/out_valid.
//   - mv[DEPTH-1] = out_ready | ~v[DEPTH-1];  mv[i] = mv[i+1] | ~v[i]  (stage i may load).
//   - in_ready = mv[0] & ~flush. Ready path is combinational across the chain (no skid).
//   - Each edge, when mv[i]: data[i] <= prior-stage data (in_data for i=0), v[i] <= prior
//     valid (in_valid & in_ready for i=0). When ~mv[i]: stage holds data and valid.
//   - Data register only loads when the incoming valid is 1; bubbles do not overwrite data.
//   - Bubble collapsing: an empty stage is filled even when downstream is stalled.
//   - Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Latency: data accepted at edge n appears on out_data after edge n+DEPTH-1 when no stall
//     (DEPTH cycles from in_fire to first out_valid cycle). Throughput 1 word/cycle.
//   - Full (all v=1, out_ready=0): in_ready=0, contents frozen. Full with out_ready=1:
//     in_ready=1, simultaneous push and pop, chain shifts by one.
//   - Empty: out_valid=0; out_data shows last loaded value of final stage (don't-care).
//   - flush=1: at next edge all v<=0 regardless of out_ready/in_valid; in_ready=0 during flush
//     so no word is accepted; out_fire in the flush cycle still counts as delivered downstream.
//     Data registers not cleared by flush.
//   - out_data/out_valid are stable while out_valid=1 and out_ready=0 (AXI-style hold).
//   - in_ready may depend on out_ready combinationally; in_valid must not depend on in_ready.
// CONFIGURATION
//   - PIPE_REG_CHAIN_OCC_EN defined: occupancy port present; register updates each edge as
//     occupancy + in_fire - out_fire; cleared to 0 by flush (flush wins over fire events);
//     always equals popcount(v); never exceeds DEPTH nor underflows.
//   - Undefined: occupancy port and counter absent; all other behaviour identical.
// TESTING  (WIDTH=32, DEPTH=3 unless stated)
//   - Reset: rst=0 mid-stream with 2 stages valid -> out_valid=0, out_data=0, occupancy=0
//     immediately, before next clk edge.
//   - Streaming: out_ready=1, push 0x1..0x8 back-to-back -> first out_valid 3 cycles after
//     first in_fire, words out in order 0x1..0x8 on consecutive cycles, in_ready never 0.
//   - Backpressure: out_ready=0, push 0xA,0xB,0xC,0xD -> 3 accepted, in_ready=0 on 4th,
//     occupancy=3, out_data=0xA held; out_ready=1 -> 0xD accepted same cycle 0xA pops.
//   - Bubble collapse: push 0x11, idle 2 cycles, push 0x22 with out_ready=0 -> both held in
//     last two stages; out_ready=1 yields 0x11 then 0x22 on consecutive cycles.
//   - Flush: 3 valid, assert flush with in_valid=1 -> in_ready=0, next cycle out_valid=0,
//     occupancy=0, pushed word dropped; following push 0x55 emerges after 3 cycles.
//   - DEPTH=1: push/pop same cycle while full -> sustained 1 word/cycle, data order preserved.

Source files
------------

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_chain
// Brief    : DEPTH-stage valid/ready register chain with bubble collapsing and
//            synchronous flush. Define PIPE_REG_CHAIN_OCC_EN for occupancy port.
// Revision : 1.0  initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0]            w_may_load;
    logic [DEPTH-1:0][WIDTH-1:0] w_prev_data;
    logic [DEPTH-1:0]            w_prev_valid;
    logic                        w_in_fire;

    // A stage may load when any stage between it and the output is empty,
    // or the output is being drained this cycle.
    always_comb begin
        logic room;
        w_may_load = '0;
        room       = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            room          = room | ~r_valid[i];
            w_may_load[i] = room;
        end
    end

    assign in_ready  = w_may_load[0] & ~flush;
    assign w_in_fire = in_valid & in_ready;

    if (DEPTH == 1) begin : g_single
        assign w_prev_data  = in_data;
        assign w_prev_valid = w_in_fire;
    end else begin : g_chain
        assign w_prev_data  = {r_data[DEPTH-2:0], in_data};
        assign w_prev_valid = {r_valid[DEPTH-2:0], w_in_fire};
    end

    // Data only follows a valid word so bubbles never overwrite held data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_may_load[i]) begin
                    r_valid[i] <= w_prev_valid[i];
                end
                if (w_may_load[i] && w_prev_valid[i]) begin
                    r_data[i] <= w_prev_data[i];
                end
            end
        end
    end

    assign out_data  = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [c_OCC_W-1:0] r_occ;
    logic               w_out_fire;

    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occ <= r_occ + c_OCC_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_occ <= r_occ - c_OCC_W'(1);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_reg_chain
// Brief    : Self-checking bench for pipe_reg_chain (DEPTH=3 and DEPTH=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        ir3, ov3, ir1, ov1;
    logic [31:0] od3, od1;
`ifdef PIPE_REG_CHAIN_OCC_EN
    logic [1:0]  occ3;
    logic [0:0]  occ1;
`endif

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(out_ready)
`ifdef PIPE_REG_CHAIN_OCC_EN
        , .occupancy(occ3)
`endif
    );

    pipe_reg_chain #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready)
`ifdef PIPE_REG_CHAIN_OCC_EN
        , .occupancy(occ1)
`endif
    );

    // Selected DUT outputs for the model-checked phase
    logic        sel;
    logic        ir_o, ov_o;
    logic [31:0] od_o;
    always_comb begin
        ir_o = sel ? ir1 : ir3;
        ov_o = sel ? ov1 : ov3;
        od_o = sel ? od1 : od3;
    end
`ifdef PIPE_REG_CHAIN_OCC_EN
    int occ_o;
    always_comb occ_o = sel ? int'(occ1) : int'(occ3);
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model: ordered list of words with positions
    typedef struct {
        logic [31:0] d;
        int          s;
    } ent_t;
    ent_t mq[$];
    int   npos[$];
    int   mdepth;
    localparam int GONE = 1 << 20;

    // Oldest word advances (or leaves); each younger word advances if the slot
    // ahead is vacated by the time the older word has moved.
    function automatic void m_moves();
        int prev;
        npos.delete();
        prev = GONE;
        foreach (mq[k]) begin
            int np;
            if (k == 0)
                np = (mq[0].s == mdepth - 1) ? (out_ready ? GONE : mq[0].s) : mq[0].s + 1;
            else
                np = (prev > mq[k].s + 1) ? mq[k].s + 1 : mq[k].s;
            npos.push_back(np);
            prev = np;
        end
    endfunction

    task automatic m_update(input logic rdy);
        ent_t nq[$];
        if (flush) begin
            mq.delete();
        end else begin
            foreach (mq[k]) if (npos[k] < mdepth) nq.push_back('{d: mq[k].d, s: npos[k]});
            if (in_valid && rdy) nq.push_back('{d: in_data, s: 0});
            mq = nq;
        end
    endtask

    task automatic tick_rnd();
        logic exp_ir, exp_ov;
        @(negedge clk);
        m_moves();
        exp_ir = !flush && !(mq.size() > 0 && npos[npos.size()-1] == 0);
        exp_ov = (mq.size() > 0) && (mq[0].s == mdepth - 1);
        chk("rnd_in_ready", {31'd0, ir_o}, {31'd0, exp_ir});
        chk("rnd_out_valid", {31'd0, ov_o}, {31'd0, exp_ov});
        if (exp_ov) chk("rnd_out_data", od_o, mq[0].d);
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("rnd_occupancy", occ_o, mq.size());
`endif
        @(posedge clk);
        m_update(exp_ir);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        mq.delete();
    endtask

    // ---------------- directed vector table (DEPTH=3)
    typedef struct {
        logic        rs, fl, iv;
        logic [31:0] d;
        logic        ordy, eir, eov;
        logic [31:0] eod;
        int          eocc;
    } vec_t;
    vec_t tab[$];

    function automatic void row(logic fl, logic iv, logic [31:0] d, logic ordy,
                                logic eir, logic eov, logic [31:0] eod, int eocc);
        vec_t v;
        v.rs = 1'b0; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.eod = eod; v.eocc = eocc;
        tab.push_back(v);
    endfunction

    function automatic void rrst();
        vec_t v;
        v = '{default: '0};
        v.rs = 1'b1;
        tab.push_back(v);
    endfunction

    task automatic tick_tab(input vec_t v);
        flush = v.fl; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
        @(negedge clk);
        chk("tab_in_ready", {31'd0, ir3}, {31'd0, v.eir});
        chk("tab_out_valid", {31'd0, ov3}, {31'd0, v.eov});
        if (v.eov) chk("tab_out_data", od3, v.eod);
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("tab_occupancy", {30'd0, occ3}, v.eocc);
`endif
        @(posedge clk); #1;
    endtask

    function automatic void fill_table();
        // backpressure
        rrst();
        row(0, 1, 32'hA, 0, 1, 0, 0,     0);
        row(0, 1, 32'hB, 0, 1, 0, 0,     1);
        row(0, 1, 32'hC, 0, 1, 0, 0,     2);
        row(0, 1, 32'hD, 0, 0, 1, 32'hA, 3);
        row(0, 1, 32'hD, 1, 1, 1, 32'hA, 3);
        row(0, 0, 0,     1, 1, 1, 32'hB, 3);
        row(0, 0, 0,     1, 1, 1, 32'hC, 2);
        row(0, 0, 0,     1, 1, 1, 32'hD, 1);
        row(0, 0, 0,     1, 1, 0, 0,     0);
        // streaming 1..8
        rrst();
        for (int k = 0; k < 12; k++)
            row(0, logic'(k < 8), (k < 8) ? 32'(k + 1) : 32'd0, 1, 1,
                logic'(k >= 3 && k <= 10), 32'(k - 2),
                (k < 3) ? k : ((k <= 8) ? 3 : 11 - k));
        // bubble collapse
        rrst();
        row(0, 1, 32'h11, 0, 1, 0, 0,      0);
        row(0, 0, 0,      0, 1, 0, 0,      1);
        row(0, 0, 0,      0, 1, 0, 0,      1);
        row(0, 1, 32'h22, 0, 1, 1, 32'h11, 1);
        row(0, 0, 0,      0, 1, 1, 32'h11, 2);
        row(0, 0, 0,      0, 1, 1, 32'h11, 2);
        row(0, 0, 0,      1, 1, 1, 32'h11, 2);
        row(0, 0, 0,      1, 1, 1, 32'h22, 1);
        row(0, 0, 0,      1, 1, 0, 0,      0);
        // flush with a push attempt
        rrst();
        row(0, 1, 32'hE1, 0, 1, 0, 0,      0);
        row(0, 1, 32'hE2, 0, 1, 0, 0,      1);
        row(0, 1, 32'hE3, 0, 1, 0, 0,      2);
        row(1, 1, 32'h99, 0, 0, 1, 32'hE1, 3);
        row(0, 1, 32'h55, 1, 1, 0, 0,      0);
        row(0, 0, 0,      1, 1, 0, 0,      1);
        row(0, 0, 0,      1, 1, 0, 0,      1);
        row(0, 0, 0,      1, 1, 1, 32'h55, 1);
        row(0, 0, 0,      1, 1, 0, 0,      0);
    endfunction

    initial begin
        sel = 1'b0;
        mdepth = 3;
        fill_table();
        do_reset();

        @(negedge clk);
        chk("reset_out_valid", {31'd0, ov3}, 32'd0);
        chk("reset_out_data", od3, 32'd0);
        chk("reset_in_ready", {31'd0, ir3}, 32'd1);
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("reset_occupancy", {30'd0, occ3}, 32'd0);
`endif
        @(posedge clk); #1;

        foreach (tab[i]) begin
            if (tab[i].rs) do_reset();
            else tick_tab(tab[i]);
        end

        // asynchronous reset mid-stream with the last two stages valid
        do_reset();
        in_valid = 1'b1; in_data = 32'h0000_0A0A;
        @(posedge clk); #1;
        in_data = 32'h0000_0B0B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_out_valid", {31'd0, ov3}, 32'd1);
        chk("pre_reset_out_data", od3, 32'h0000_0A0A);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_out_valid", {31'd0, ov3}, 32'd0);
        chk("async_reset_out_data", od3, 32'd0);
        chk("async_reset_d1_out_valid", {31'd0, ov1}, 32'd0);
        chk("async_reset_d1_out_data", od1, 32'd0);
`ifdef PIPE_REG_CHAIN_OCC_EN
        chk("async_reset_occupancy", {30'd0, occ3}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;

        // DEPTH=1: sustained push and pop while full
        do_reset();
        for (int k = 0; k < 6; k++) begin
            flush = 1'b0; in_valid = 1'b1; in_data = 32'h100 + 32'(k); out_ready = 1'b1;
            @(negedge clk);
            chk("d1_in_ready", {31'd0, ir1}, 32'd1);
            if (k > 0) begin
                chk("d1_out_valid", {31'd0, ov1}, 32'd1);
                chk("d1_out_data", od1, 32'h100 + 32'(k - 1));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("d1_full_stall_in_ready", {31'd0, ir1}, 32'd0);
        chk("d1_full_stall_out_data", od1, 32'h105);
        @(posedge clk); #1;

        // randomized against the model, DEPTH=3 then DEPTH=1
        for (int p = 0; p < 2; p++) begin
            sel = (p == 1);
            mdepth = (p == 1) ? 1 : 3;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                flush     = ($urandom_range(0, 19) == 0);
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 2) != 0);
                tick_rnd();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
